// File: rtl/alu_mdu_if.sv
// EX-stage bus between the pipeline and the ALU-control / multiply-divide unit.
interface alu_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       func;
  logic [2:0]       EX_ALUOp;
  logic             ex_valid;
  logic             flush;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       AluCtrlOut;
  logic             undefine;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output func, EX_ALUOp, ex_valid, flush, src_a, src_b,
    input  AluCtrlOut, undefine, stall, busy, hi, lo
  );

  modport slave (
    input  func, EX_ALUOp, ex_valid, flush, src_a, src_b,
    output AluCtrlOut, undefine, stall, busy, hi, lo
  );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus iterative multiply/divide unit owning HI/LO.
// Divider present only when ALU_MDU_DIV_EN is defined.
module alu_mdu_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic        clk,
  input logic        rst_n,
  alu_mdu_if.slave   bus
);
  localparam logic [3:0] C_UNDEF = 4'b0100;
  localparam logic [3:0] C_MDNOP = 4'b1100;
  localparam logic [3:0] C_MFHI  = 4'b1010;
  localparam logic [3:0] C_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [3:0]       alu_ctrl;
  logic             is_md, is_mfhx, accept, done_wr, iter_last;
  logic             busy_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q, lo_q, acc_hi, acc_lo, mag_b;
  logic             neg_hi;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;
`ifdef ALU_MDU_DIV_EN
  logic             is_mul, div_zero, neg_lo, res_mul, div_ge;
  logic [WIDTH:0]   div_sh, div_diff;
`endif

  // ALU operation decode
  always_comb begin
    alu_ctrl = C_UNDEF;
    case (bus.EX_ALUOp)
      3'b000: alu_ctrl = 4'b0010;
      3'b001: alu_ctrl = 4'b0110;
      3'b011: alu_ctrl = 4'b0101;
      3'b100: alu_ctrl = 4'b0001;
      3'b010: begin
        case (bus.func)
          6'b100000: alu_ctrl = 4'b0010;
          6'b100010: alu_ctrl = 4'b0110;
          6'b100100: alu_ctrl = 4'b0000;
          6'b100101: alu_ctrl = 4'b0001;
          6'b101010: alu_ctrl = 4'b0111;
          6'b100110: alu_ctrl = 4'b0011;
          6'b100111: alu_ctrl = 4'b1000;
          6'b101011: alu_ctrl = 4'b1001;
          6'b010000: alu_ctrl = C_MFHI;
          6'b010010: alu_ctrl = C_MFLO;
          6'b011000, 6'b011001: alu_ctrl = C_MDNOP;
`ifdef ALU_MDU_DIV_EN
          6'b011010, 6'b011011: alu_ctrl = C_MDNOP;
`endif
          default: alu_ctrl = C_UNDEF;
        endcase
      end
      default: alu_ctrl = C_UNDEF;
    endcase
  end

  assign is_md     = (alu_ctrl == C_MDNOP);
  assign is_mfhx   = (alu_ctrl == C_MFHI) || (alu_ctrl == C_MFLO);
  assign iter_last = (cnt == CNT_W'(WIDTH - 1));
  assign done_wr   = (state == S_DONE) && !bus.flush;
`ifdef ALU_MDU_DIV_EN
  assign is_mul    = !bus.func[1];
  assign div_zero  = (bus.src_b == '0);
`endif

  assign bus.AluCtrlOut = alu_ctrl;
  assign bus.undefine   = (alu_ctrl == C_UNDEF);
  assign bus.stall      = busy_q && bus.ex_valid && (is_md || is_mfhx);
  assign bus.busy       = busy_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != S_IDLE);
    end
  end

  // Next state; flush overrides both accept and the DONE write
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ex_valid && is_md) begin
          accept     = 1'b1;
          state_next = S_MUL;
`ifdef ALU_MDU_DIV_EN
          if (!is_mul) state_next = div_zero ? S_DONE : S_DIV;
`endif
        end
      end
      S_MUL:  if (iter_last) state_next = S_DONE;
`ifdef ALU_MDU_DIV_EN
      S_DIV:  if (iter_last) state_next = S_DONE;
`endif
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush) begin
      state_next = S_IDLE;
      accept     = 1'b0;
    end
  end

  // Operand magnitudes; func[0]=0 selects the signed variant
  assign a_neg    = !bus.func[0] && bus.src_a[WIDTH-1];
  assign b_neg    = !bus.func[0] && bus.src_b[WIDTH-1];
  assign mag_a_in = a_neg ? -bus.src_a : bus.src_a;
  assign mag_b_in = b_neg ? -bus.src_b : bus.src_b;

  // One shift-add step: {acc_hi,acc_lo} starts as {0,a} and shifts right
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
  assign prod_fix = neg_hi ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef ALU_MDU_DIV_EN
  // One restoring step: remainder in acc_hi, dividend shifts out of acc_lo as quotient shifts in
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mag_b};
  assign div_ge   = (div_sh >= {1'b0, mag_b});
  assign res_hi   = res_mul ? prod_fix[2*WIDTH-1:WIDTH] : (neg_hi ? -acc_hi : acc_hi);
  assign res_lo   = res_mul ? prod_fix[WIDTH-1:0]       : (neg_lo ? -acc_lo : acc_lo);
`else
  assign res_hi   = prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = prod_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mag_b   <= '0;
      neg_hi  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_MDU_DIV_EN
      neg_lo  <= 1'b0;
      res_mul <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= mag_a_in;
        mag_b  <= mag_b_in;
        neg_hi <= a_neg ^ b_neg;
`ifdef ALU_MDU_DIV_EN
        res_mul <= is_mul;
        neg_lo  <= a_neg ^ b_neg;
        if (!is_mul) neg_hi <= a_neg;
        // Divide by zero: preload the architectural result, no sign fixup
        if (!is_mul && div_zero) begin
          acc_hi <= bus.src_a;
          acc_lo <= '1;
          neg_hi <= 1'b0;
          neg_lo <= 1'b0;
        end
`endif
      end else if (state == S_MUL) begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        cnt    <= cnt + CNT_W'(1);
`ifdef ALU_MDU_DIV_EN
      end else if (state == S_DIV) begin
        acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
        cnt    <= cnt + CNT_W'(1);
`endif
      end
      if (done_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed self-checking bench for alu_mdu_ctrl (default WIDTH=32).
module tb_alu_mdu_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_mdu_if #(.WIDTH(WIDTH)) bus ();
  alu_mdu_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #1;
  endtask

  task drive(input logic [2:0] op, input logic [5:0] fn, input logic v,
             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.EX_ALUOp = op;
    bus.func     = fn;
    bus.ex_valid = v;
    bus.src_a    = a;
    bus.src_b    = b;
  endtask

  task test_reset;
    bus.flush = 1'b0;
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    rst_n = 1'b0;
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset lo: got %h expected 0", bus.lo); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", bus.stall); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task test_decode;
    logic [2:0] ops  [22];
    logic [5:0] fns  [22];
    logic [3:0] exps [22];
    logic [3:0] div_code;
`ifdef ALU_MDU_DIV_EN
    div_code = 4'b1100;
`else
    div_code = 4'b0100;
`endif
    ops[0]  = 3'b000; fns[0]  = 6'b100010; exps[0]  = 4'b0010;
    ops[1]  = 3'b001; fns[1]  = 6'b100000; exps[1]  = 4'b0110;
    ops[2]  = 3'b011; fns[2]  = 6'b000000; exps[2]  = 4'b0101;
    ops[3]  = 3'b100; fns[3]  = 6'b111111; exps[3]  = 4'b0001;
    ops[4]  = 3'b111; fns[4]  = 6'b100000; exps[4]  = 4'b0100;
    ops[5]  = 3'b101; fns[5]  = 6'b100000; exps[5]  = 4'b0100;
    ops[6]  = 3'b110; fns[6]  = 6'b100000; exps[6]  = 4'b0100;
    ops[7]  = 3'b010; fns[7]  = 6'b100000; exps[7]  = 4'b0010;
    ops[8]  = 3'b010; fns[8]  = 6'b100010; exps[8]  = 4'b0110;
    ops[9]  = 3'b010; fns[9]  = 6'b100100; exps[9]  = 4'b0000;
    ops[10] = 3'b010; fns[10] = 6'b100101; exps[10] = 4'b0001;
    ops[11] = 3'b010; fns[11] = 6'b101010; exps[11] = 4'b0111;
    ops[12] = 3'b010; fns[12] = 6'b100110; exps[12] = 4'b0011;
    ops[13] = 3'b010; fns[13] = 6'b100111; exps[13] = 4'b1000;
    ops[14] = 3'b010; fns[14] = 6'b101011; exps[14] = 4'b1001;
    ops[15] = 3'b010; fns[15] = 6'b010000; exps[15] = 4'b1010;
    ops[16] = 3'b010; fns[16] = 6'b010010; exps[16] = 4'b1011;
    ops[17] = 3'b010; fns[17] = 6'b011000; exps[17] = 4'b1100;
    ops[18] = 3'b010; fns[18] = 6'b011001; exps[18] = 4'b1100;
    ops[19] = 3'b010; fns[19] = 6'b111111; exps[19] = 4'b0100;
    ops[20] = 3'b010; fns[20] = 6'b011010; exps[20] = div_code;
    ops[21] = 3'b010; fns[21] = 6'b011011; exps[21] = div_code;
    for (int i = 0; i < 22; i++) begin
      drive(ops[i], fns[i], 1'b0, '0, '0);
      #1;
      checks++;
      if (bus.AluCtrlOut !== exps[i]) begin
        errors++;
        $display("FAIL decode[%0d] AluCtrlOut op=%b func=%b: got %b expected %b", i, ops[i], fns[i], bus.AluCtrlOut, exps[i]);
      end
      checks++;
      if (bus.undefine !== (exps[i] == 4'b0100)) begin
        errors++;
        $display("FAIL decode[%0d] undefine: got %b expected %b", i, bus.undefine, (exps[i] == 4'b0100));
      end
    end
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    step();
  endtask

  task test_mult;
    drive(3'b010, F_MULT, 1'b1, 32'hFFFFFFFD, 32'd7);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult busy_after_accept: got %b expected 1", bus.busy); end
    repeat (WIDTH) step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult busy_in_done: got %b expected 1", bus.busy); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL mult lo_early: got %h expected 00000000", bus.lo); end
    step();
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult hi: got %h expected FFFFFFFF", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult lo: got %h expected FFFFFFEB", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult busy_end: got %b expected 0", bus.busy); end
  endtask

  task test_div;
`ifdef ALU_MDU_DIV_EN
    drive(3'b010, F_DIVU, 1'b1, 32'd100, 32'd7);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (WIDTH) step();
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL divu lo_early: got %h expected FFFFFFEB", bus.lo); end
    step();
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu lo: got %h expected 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu hi: got %h expected 00000002", bus.hi); end
    drive(3'b010, F_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (WIDTH + 1) step();
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div lo: got %h expected FFFFFFFD", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div hi: got %h expected FFFFFFFF", bus.hi); end
    drive(3'b010, F_DIV, 1'b1, 32'd5, 32'd0);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL div0 busy: got %b expected 1", bus.busy); end
    step();
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0 lo: got %h expected FFFFFFFF", bus.lo); end
    checks++; if (bus.hi !== 32'd5) begin errors++; $display("FAIL div0 hi: got %h expected 00000005", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div0 busy_end: got %b expected 0", bus.busy); end
`else
    drive(3'b010, F_DIVU, 1'b1, 32'd100, 32'd7);
    #1;
    checks++; if (bus.undefine !== 1'b1) begin errors++; $display("FAIL nodiv undefine: got %b expected 1", bus.undefine); end
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nodiv busy: got %b expected 0", bus.busy); end
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (WIDTH + 1) step();
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL nodiv lo: got %h expected FFFFFFEB", bus.lo); end
`endif
  endtask

  task test_stall;
    int n;
    drive(3'b010, F_MULTU, 1'b1, 32'd6, 32'd7);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall idle: got %b expected 0", bus.stall); end
    step();
    drive(3'b010, F_ADD, 1'b1, 32'd1, 32'd1);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall add_busy: got %b expected 0", bus.stall); end
    checks++; if (bus.AluCtrlOut !== 4'b0010) begin errors++; $display("FAIL stall add_ctrl: got %b expected 0010", bus.AluCtrlOut); end
    step();
    drive(3'b010, F_MFLO, 1'b1, '0, '0);
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL stall mflo_cycles: got %0d expected 32", n); end
    checks++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL stall mflo_value: got %h expected 0000002a", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall busy_end: got %b expected 0", bus.busy); end
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    step();
  endtask

  task test_flush;
    drive(3'b010, F_MULTU, 1'b1, 32'd2, 32'h80000001);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (WIDTH + 1) step();
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd2) begin errors++; $display("FAIL flush setup: got %h_%h expected 00000001_00000002", bus.hi, bus.lo); end
    drive(3'b010, F_MULT, 1'b1, 32'd5, 32'd5);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b expected 0", bus.busy); end
    drive(3'b010, F_MULT, 1'b1, 32'd5, 32'd5);
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush over_accept busy: got %b expected 0", bus.busy); end
    bus.flush = 1'b0;
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (40) step();
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd2) begin errors++; $display("FAIL flush hilo_kept: got %h_%h expected 00000001_00000002", bus.hi, bus.lo); end
    drive(3'b010, F_MULTU, 1'b1, 32'd3, 32'd3);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (WIDTH) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd2) begin errors++; $display("FAIL flush in_done: got %h_%h expected 00000001_00000002", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush in_done busy: got %b expected 0", bus.busy); end
  endtask

  task test_reset_mid;
    drive(3'b010, F_MULTU, 1'b1, 32'd3, 32'd4);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid hilo: got %h_%h expected 00000000_00000000", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", bus.busy); end
    step();
    rst_n = 1'b1;
    drive(3'b010, F_MULTU, 1'b1, 32'd3, 32'd4);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid first_accept: got %b expected 1", bus.busy); end
    repeat (WIDTH + 1) step();
    checks++; if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid result: got %h_%h expected 00000000_0000000c", bus.hi, bus.lo); end
  endtask

  task test_back_to_back;
    drive(3'b010, F_MULTU, 1'b1, 32'd2, 32'd3);
    step();
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b held_stall: got %b expected 1", bus.stall); end
    repeat (WIDTH + 1) step();
    checks++; if (bus.lo !== 32'd6 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b first: got lo=%h busy=%b expected lo=00000006 busy=0", bus.lo, bus.busy); end
    drive(3'b010, F_MULTU, 1'b1, 32'd4, 32'd5);
    step();
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b reaccept: got %b expected 1", bus.busy); end
    repeat (WIDTH + 1) step();
    checks++; if (bus.lo !== 32'd20) begin errors++; $display("FAIL b2b second: got %h expected 00000014", bus.lo); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
